dest_drain_arb: RTL and testbench

//  Consumer stage after the destination FIFOs D0/D1 of the PCIe transaction path. Arbitrates

---
 rtl/dest_drain_arb_if.sv | 30 +++
 rtl/dest_drain_arb.sv | 68 ++++++
 tb/tb_dest_drain_arb.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/dest_drain_arb_if.sv
// dest_drain_arb_if: FIFO-side and sink-side signals of the destination drain arbiter.
interface dest_drain_arb_if #(
    parameter int DATA_W = 6,
    parameter int CNT_W  = 8
);
    logic              enable;
    logic              empty_d0;
    logic              empty_d1;
    logic [DATA_W-1:0] data_d0;
    logic [DATA_W-1:0] data_d1;
    logic              pop_d0;
    logic              pop_d1;
    logic              sink_ready;
    logic              valid_out;
    logic [DATA_W-1:0] data_out;
    logic              dest_out;
    logic              cnt_clr;
    logic [CNT_W-1:0]  cnt_d0;
    logic [CNT_W-1:0]  cnt_d1;
    logic              route_err;
    logic              idle;
    modport slave (
        input  enable, empty_d0, empty_d1, data_d0, data_d1, sink_ready, cnt_clr,
        output pop_d0, pop_d1, valid_out, data_out, dest_out, cnt_d0, cnt_d1, route_err, idle
    );
    modport master (
        output enable, empty_d0, empty_d1, data_d0, data_d1, sink_ready, cnt_clr,
        input  pop_d0, pop_d1, valid_out, data_out, dest_out, cnt_d0, cnt_d1, route_err, idle
    );
endinterface

// File: rtl/dest_drain_arb.sv
// dest_drain_arb: round-robin drain of destination FIFOs D0/D1 onto one tagged valid/ready port.
module dest_drain_arb #(
    parameter int DATA_W = 6,
    parameter int CNT_W  = 8,
    parameter int DEST_B = 4
) (
    input logic             clk,
    input logic             reset,
    dest_drain_arb_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;
    logic [1:0]        state_q, state_d;
    logic              last_q, last_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              dest_q, dest_d;
    logic [CNT_W-1:0]  cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic              err_q, err_d;
    logic              accept, grant, tgt;
    logic [DATA_W-1:0] word;
    // last_q already names the granted FIFO by the time we sit in WAIT
    always_comb begin
        accept  = state_q == HOLD && bus.sink_ready;
        grant   = !reset && bus.enable && !(bus.empty_d0 && bus.empty_d1) && (state_q == IDLE || accept);
        tgt     = last_q ? bus.empty_d0 : !bus.empty_d1;
        word    = last_q ? bus.data_d1 : bus.data_d0;
        state_d = grant ? WAIT : state_q == WAIT ? HOLD : (state_q == HOLD && !accept) ? HOLD : IDLE;
        last_d  = grant ? tgt : last_q;
        valid_d = state_q == WAIT ? 1'b1 : accept ? 1'b0 : valid_q;
        data_d  = state_q == WAIT ? word : data_q;
        dest_d  = state_q == WAIT ? last_q : dest_q;
        err_d   = err_q | (state_q == WAIT && word[DEST_B] != last_q);
        cnt0_d  = bus.cnt_clr ? '0 : (accept && !dest_q && !(&cnt0_q)) ? cnt0_q + CNT_W'(1) : cnt0_q;
        cnt1_d  = bus.cnt_clr ? '0 : (accept && dest_q && !(&cnt1_q)) ? cnt1_q + CNT_W'(1) : cnt1_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            valid_q <= 1'b0;
            data_q  <= '0;
            dest_q  <= 1'b0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            dest_q  <= dest_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
            err_q   <= err_d;
        end
    end
    assign bus.pop_d0    = grant && !tgt;
    assign bus.pop_d1    = grant && tgt;
    assign bus.valid_out = valid_q;
    assign bus.data_out  = data_q;
    assign bus.dest_out  = dest_q;
    assign bus.cnt_d0    = cnt0_q;
    assign bus.cnt_d1    = cnt1_q;
    assign bus.route_err = err_q;
    assign bus.idle      = state_q == IDLE && !valid_q;
endmodule

// File: tb/tb_dest_drain_arb.sv
// tb_dest_drain_arb: randomized scoreboard bench for dest_drain_arb.
// FIFOs are queues; a word-level model predicts pops, flags and counters, a monitor checks delivered words.
module tb_dest_drain_arb;
    localparam int DATA_W = 6;
    localparam int CNT_W  = 8;
    localparam int DEST_B = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;
    typedef struct packed {
        logic              dest;
        logic [DATA_W-1:0] data;
    } word_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    dest_drain_arb_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();
    dest_drain_arb #(.DATA_W(DATA_W), .CNT_W(CNT_W), .DEST_B(DEST_B)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );
    always #5 clk = ~clk;
    int vectors = 0;
    int miscompares = 0;
    logic [DATA_W-1:0] q0[$];
    logic [DATA_W-1:0] q1[$];
    word_t sb[$];
    int pops0 = 0, pops1 = 0, served0 = 0, served1 = 0;
    bit m_inflight, m_just, m_last, m_err, m_dest, m_dout_dest;
    logic [DATA_W-1:0] m_cur, m_dout, w;
    int m_cnt0, m_cnt1;
    bit vis, acc, g, tgt;
    word_t e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: checked at each falling edge, then advanced to the next rising edge.
    always @(negedge clk) begin
        if (bus.pop_d0) pops0++;
        if (bus.pop_d1) pops1++;
        if (reset) begin
            sb.delete();
            m_inflight = 0;
            m_just = 0;
            m_last = 1;
            m_err = 0;
            m_cnt0 = 0;
            m_cnt1 = 0;
            m_dout = '0;
            m_dout_dest = 0;
            m_dest = 0;
        end else begin
            vis = m_inflight && !m_just;
            acc = vis && bus.sink_ready;
            g = bus.enable && (q0.size() > 0 || q1.size() > 0) && (!m_inflight || acc);
            tgt = (m_last == 1) ? (q0.size() > 0 ? 1'b0 : 1'b1) : (q1.size() > 0 ? 1'b1 : 1'b0);
            chk("pop_d0", bus.pop_d0, g && !tgt);
            chk("pop_d1", bus.pop_d1, g && tgt);
            chk("valid_out", bus.valid_out, vis);
            chk("idle", bus.idle, !m_inflight);
            chk("cnt_d0", bus.cnt_d0, m_cnt0);
            chk("cnt_d1", bus.cnt_d1, m_cnt1);
            chk("route_err", bus.route_err, m_err);
            chk("data_out_held", bus.data_out, m_dout);
            chk("dest_out_held", bus.dest_out, m_dout_dest);
            if (acc && m_dest == 0) m_cnt0 = (m_cnt0 == CMAX) ? CMAX : m_cnt0 + 1;
            if (acc && m_dest == 1) m_cnt1 = (m_cnt1 == CMAX) ? CMAX : m_cnt1 + 1;
            if (bus.cnt_clr) begin
                m_cnt0 = 0;
                m_cnt1 = 0;
            end
            if (m_just) begin
                m_err = m_err | (m_cur[DEST_B] != m_dest);
                m_dout = m_cur;
                m_dout_dest = m_dest;
            end
            if (g) begin
                w = tgt ? q1[0] : q0[0];
                sb.push_back('{tgt, w});
                m_cur = w;
                m_dest = tgt;
                m_last = tgt;
                m_inflight = 1;
                m_just = 1;
            end else begin
                m_just = 0;
                if (acc) m_inflight = 0;
            end
        end
    end

    // Monitor: every word the sink takes must be the oldest predicted word.
    always @(negedge clk) begin
        if (!reset && bus.valid_out && bus.sink_ready) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", {bus.dest_out, bus.data_out}, 32'hffff_ffff);
            end else begin
                e = sb.pop_front();
                chk("data_out", bus.data_out, e.data);
                chk("dest_out", bus.dest_out, e.dest);
            end
        end
    end

    // FIFO side: a pop strobe seen in one cycle presents the word during the next.
    task automatic tick();
        @(posedge clk);
        #1;
        while (served0 < pops0) begin
            if (q0.size() > 0) bus.data_d0 = q0.pop_front();
            served0++;
        end
        while (served1 < pops1) begin
            if (q1.size() > 0) bus.data_d1 = q1.pop_front();
            served1++;
        end
        bus.empty_d0 = q0.size() == 0;
        bus.empty_d1 = q1.size() == 0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push0(input logic [DATA_W-1:0] v);
        q0.push_back(v);
        bus.empty_d0 = 1'b0;
    endtask

    task automatic push1(input logic [DATA_W-1:0] v);
        q1.push_back(v);
        bus.empty_d1 = 1'b0;
    endtask

    initial begin
        bus.enable = 1'b1;
        bus.empty_d0 = 1'b1;
        bus.empty_d1 = 1'b1;
        bus.data_d0 = '0;
        bus.data_d1 = '0;
        bus.sink_ready = 1'b1;
        bus.cnt_clr = 1'b0;
        run(3);
        reset = 1'b0;
        run(2);
        push0(6'h05);
        run(6);
        reset = 1'b1;
        run(2);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push0(6'(i + 1));
            push1(6'h10 | 6'(i));
        end
        run(16);
        push1(6'h12);
        bus.sink_ready = 1'b0;
        run(7);
        bus.sink_ready = 1'b1;
        run(4);
        bus.cnt_clr = 1'b1;
        tick();
        bus.cnt_clr = 1'b0;
        for (int i = 0; i < 260; i++) begin
            push1(6'h10 | 6'($urandom_range(0, 15)));
            run(2);
        end
        run(6);
        push1(6'h1f);
        bus.sink_ready = 1'b0;
        run(4);
        bus.sink_ready = 1'b1;
        bus.cnt_clr = 1'b1;
        tick();
        bus.cnt_clr = 1'b0;
        run(3);
        push0(6'h10);
        run(4);
        push0(6'h03);
        push1(6'h17);
        run(8);
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 2) == 0 && q0.size() < 6) push0(6'($urandom));
            if ($urandom_range(0, 2) == 0 && q1.size() < 6) push1(6'($urandom));
            bus.sink_ready = $urandom_range(0, 3) != 0;
            bus.enable = $urandom_range(0, 7) != 0;
            bus.cnt_clr = $urandom_range(0, 49) == 0;
            tick();
        end
        bus.sink_ready = 1'b1;
        bus.enable = 1'b1;
        bus.cnt_clr = 1'b0;
        run(30);
        push0(6'h21);
        push1(6'h32);
        tick();
        reset = 1'b1;
        bus.enable = 1'b0;
        run(2);
        reset = 1'b0;
        push0(6'h04);
        push1(6'h18);
        run(8);
        bus.enable = 1'b1;
        run(20);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
